// File: rtl/wb_dual_master_arbiter_if.sv
// Bus bundle for wb_dual_master_arbiter.
// Carries both master request/response groups, the shared slave-side
// request/response group and the ownership indication.
//   slave  modport : the arbiter's view (i_* inputs, o_* outputs)
//   master modport : the surrounding environment's view (drives i_*, reads o_*)
interface wb_dual_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // master A (DEPP bridge)
  logic          i_a_cyc;
  logic          i_a_stb;
  logic          i_a_we;
  logic [AW-1:0] i_a_addr;
  logic [DW-1:0] i_a_data;
  logic          o_a_ack;
  logic          o_a_stall;
  logic          o_a_err;
  // master B (parallel-port bridge)
  logic          i_b_cyc;
  logic          i_b_stb;
  logic          i_b_we;
  logic [AW-1:0] i_b_addr;
  logic [DW-1:0] i_b_data;
  logic          o_b_ack;
  logic          o_b_stall;
  logic          o_b_err;
  // shared read data and slave side
  logic [DW-1:0] o_rd_data;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic          i_wb_err;
  logic [DW-1:0] i_wb_data;
  // {B owns, A owns}
  logic [1:0]    o_grant;

  modport slave (
    input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
    output o_a_ack, o_a_stall, o_a_err,
    input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
    output o_b_ack, o_b_stall, o_b_err,
    output o_rd_data,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
    output o_grant
  );

  modport master (
    output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
    input  o_a_ack, o_a_stall, o_a_err,
    output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
    input  o_b_ack, o_b_stall, o_b_err,
    input  o_rd_data,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
    input  o_grant
  );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Two-master round-robin arbiter for a pipelined Wishbone slave bus.
// Ownership is decided per bus cycle (cyc) from a registered owner; request
// fields are muxed from that owner and responses are steered to it only.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      wb_dual_master_arbiter_if.slave: master A/B requests and
//            responses, slave-side request/response, o_grant {B, A}
// Optional: define WBARB_TIMEOUT_EN to add a bus watchdog (TIMEOUT_CYCLES)
// that errors the owner and drains the bus when the slave stops answering.
module wb_dual_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  wb_dual_master_arbiter_if.slave   bus
);

`ifdef WBARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
`endif

  state_t     state;
  logic       last_b;   // last released owner was B
  logic [1:0] grant;
  logic       own_a;
  logic       own_b;
  logic       a_live;   // A owns and still holds cyc
  logic       b_live;
  logic       hit;      // watchdog expiry this cycle

  always_comb begin
    own_a  = (state == OWN_A);
    own_b  = (state == OWN_B);
    a_live = own_a & bus.i_a_cyc;
    b_live = own_b & bus.i_b_cyc;
  end

`ifdef WBARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;

  // Counts owned cycles with cyc held; any slave response, or any cycle
  // without a live owner (covers every new grant), restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!(a_live | b_live) || bus.i_wb_ack || bus.i_wb_err) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    hit = (a_live | b_live) & ~bus.i_wb_ack & ~bus.i_wb_err &
          (cnt == CW'(TIMEOUT_CYCLES - 1));
  end
`else
  always_comb begin
    hit = 1'b0;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      last_b <= 1'b1;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the master that did not own last wins.
          if (bus.i_a_cyc && (!bus.i_b_cyc || last_b)) begin
            state <= OWN_A;
            grant <= 2'b01;
          end else if (bus.i_b_cyc) begin
            state <= OWN_B;
            grant <= 2'b10;
          end
        end
        OWN_A: begin
`ifdef WBARB_TIMEOUT_EN
          if (hit) begin
            state  <= DRAIN;
            grant  <= '0;
            last_b <= 1'b0;
          end else
`endif
          if (!bus.i_a_cyc) begin
            last_b <= 1'b0;
            if (bus.i_b_cyc) begin
              state <= OWN_B;
              grant <= 2'b10;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        OWN_B: begin
`ifdef WBARB_TIMEOUT_EN
          if (hit) begin
            state  <= DRAIN;
            grant  <= '0;
            last_b <= 1'b1;
          end else
`endif
          if (!bus.i_b_cyc) begin
            last_b <= 1'b1;
            if (bus.i_a_cyc) begin
              state <= OWN_A;
              grant <= 2'b01;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
`ifdef WBARB_TIMEOUT_EN
        // last_b already names the timed-out owner; wait for it to let go.
        DRAIN: begin
          if (last_b ? !bus.i_b_cyc : !bus.i_a_cyc) begin
            state <= IDLE;
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Request side follows the registered owner; dropping cyc or a watchdog
  // expiry takes the slave bus low in the same cycle.
  always_comb begin
    bus.o_wb_cyc  = (a_live | b_live) & ~hit;
    bus.o_wb_stb  = ((a_live & bus.i_a_stb) | (b_live & bus.i_b_stb)) & ~hit;
    bus.o_wb_we   = ((a_live & bus.i_a_we) | (b_live & bus.i_b_we)) & ~hit;
    bus.o_wb_addr = '0;
    bus.o_wb_data = '0;
    if (own_a) begin
      bus.o_wb_addr = bus.i_a_addr;
      bus.o_wb_data = bus.i_a_data;
    end else if (own_b) begin
      bus.o_wb_addr = bus.i_b_addr;
      bus.o_wb_data = bus.i_b_data;
    end
    bus.o_a_ack   = a_live & bus.i_wb_ack;
    bus.o_a_err   = a_live & (bus.i_wb_err | hit);
    bus.o_a_stall = (a_live & ~hit) ? bus.i_wb_stall : 1'b1;
    bus.o_b_ack   = b_live & bus.i_wb_ack;
    bus.o_b_err   = b_live & (bus.i_wb_err | hit);
    bus.o_b_stall = (b_live & ~hit) ? bus.i_wb_stall : 1'b1;
    bus.o_rd_data = bus.i_wb_data;
    bus.o_grant   = grant;
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Self-checking bench for wb_dual_master_arbiter. Acks are checked against a
// scoreboard queue filled when the bench schedules a slave response.
module tb_wb_dual_master_arbiter;
`ifdef WBARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic i_clk;
  logic i_rst_n;
  wb_dual_master_arbiter_if #(.AW(32), .DW(32)) bus ();

  wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acks_b = 0;
  logic [32:0] exp_q[$];   // {master (1 = B), read data}

  task automatic clear_inputs();
    bus.i_a_cyc = 0; bus.i_a_stb = 0; bus.i_a_we = 0; bus.i_a_addr = '0; bus.i_a_data = '0;
    bus.i_b_cyc = 0; bus.i_b_stb = 0; bus.i_b_we = 0; bus.i_b_addr = '0; bus.i_b_data = '0;
    bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_wb_err = 0; bus.i_wb_data = '0;
  endtask

  task automatic sb_check();
    logic [32:0] e;
    if (bus.o_a_ack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL sb_a_ack unexpected ack, data %h, none expected", bus.o_rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({1'b0, bus.o_rd_data} !== e) begin
          n_bad++; $display("FAIL sb_a_ack got A/%h want %0s/%h", bus.o_rd_data, e[32] ? "B" : "A", e[31:0]);
        end
      end
    end
    if (bus.o_b_ack) begin
      n_cmp++;
      acks_b++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL sb_b_ack unexpected ack, data %h, none expected", bus.o_rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({1'b1, bus.o_rd_data} !== e) begin
          n_bad++; $display("FAIL sb_b_ack got B/%h want %0s/%h", bus.o_rd_data, e[32] ? "B" : "A", e[31:0]);
        end
      end
    end
  endtask

  task automatic obs();
    @(negedge i_clk);
    sb_check();
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant got %b want 00", bus.o_grant); end
    n_cmp++; if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 3'b000) begin n_bad++; $display("FAIL rst_req got %b want 000", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we}); end
    n_cmp++; if ({bus.o_wb_addr, bus.o_wb_data} !== 64'd0) begin n_bad++; $display("FAIL rst_addr_data got %h want 0", {bus.o_wb_addr, bus.o_wb_data}); end
    n_cmp++; if ({bus.o_a_stall, bus.o_a_ack, bus.o_a_err, bus.o_b_stall, bus.o_b_ack, bus.o_b_err} !== 6'b100100) begin
      n_bad++; $display("FAIL rst_resp got %b want 100100", {bus.o_a_stall, bus.o_a_ack, bus.o_a_err, bus.o_b_stall, bus.o_b_ack, bus.o_b_err});
    end
    nxt();
    i_rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_a_read();
    bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_we = 0; bus.i_a_addr = 32'h0000_0010;
    obs();
    n_cmp++; if (bus.o_wb_stb !== 1'b0) begin n_bad++; $display("FAIL a_rd_latency stb got %b want 0", bus.o_wb_stb); end
    n_cmp++; if (bus.o_a_stall !== 1'b1) begin n_bad++; $display("FAIL a_rd_idle_stall got %b want 1", bus.o_a_stall); end
    nxt();
    obs();
    n_cmp++; if (bus.o_wb_stb !== 1'b1 || bus.o_wb_addr !== 32'h10) begin n_bad++; $display("FAIL a_rd_req stb/addr got %b/%h want 1/00000010", bus.o_wb_stb, bus.o_wb_addr); end
    n_cmp++; if (bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL a_rd_grant got %b want 01", bus.o_grant); end
    n_cmp++; if (bus.o_a_stall !== 1'b0) begin n_bad++; $display("FAIL a_rd_stall got %b want 0", bus.o_a_stall); end
    nxt();
    bus.i_a_stb = 0;
    obs();
    nxt();
    bus.i_wb_ack = 1; bus.i_wb_data = 32'hDEAD_BEEF;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    obs();
    nxt();
    bus.i_wb_ack = 0; bus.i_a_cyc = 0;
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL a_rd_release_cyc got %b want 0", bus.o_wb_cyc); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL a_rd_idle_grant got %b want 00", bus.o_grant); end
    nxt();
  endtask

  task automatic test_tie();
    do_reset();
    bus.i_a_cyc = 1; bus.i_b_cyc = 1;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL tie_idle got %b want 00", bus.o_grant); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01 || bus.o_wb_cyc !== 1'b1) begin n_bad++; $display("FAIL tie1_grant got %b/%b want 01/1", bus.o_grant, bus.o_wb_cyc); end
    n_cmp++; if (bus.o_b_stall !== 1'b1) begin n_bad++; $display("FAIL tie1_b_stall got %b want 1", bus.o_b_stall); end
    nxt();
    bus.i_a_cyc = 0;
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0 || bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL tie1_gap got %b/%b want 0/01", bus.o_wb_cyc, bus.o_grant); end
    nxt();
    bus.i_a_cyc = 1;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b10 || bus.o_wb_cyc !== 1'b1) begin n_bad++; $display("FAIL tie1_handover got %b/%b want 10/1", bus.o_grant, bus.o_wb_cyc); end
    nxt();
    bus.i_b_cyc = 0;
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL tie_b_gap got %b want 0", bus.o_wb_cyc); end
    nxt();
    bus.i_a_cyc = 0;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL tie_b_to_a got %b want 01", bus.o_grant); end
    nxt();
    bus.i_a_cyc = 1; bus.i_b_cyc = 1;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL tie2_idle got %b want 00", bus.o_grant); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b10) begin n_bad++; $display("FAIL tie2_grant got %b want 10", bus.o_grant); end
    nxt();
    bus.i_b_cyc = 0;
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0 || bus.o_grant !== 2'b10) begin n_bad++; $display("FAIL tie2_gap got %b/%b want 0/10", bus.o_wb_cyc, bus.o_grant); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL tie2_after got %b want 01", bus.o_grant); end
    nxt();
    bus.i_a_cyc = 0;
    nxt();
  endtask

  task automatic test_b_burst();
    int   beat;
    int   pushed;
    logic pend;
    logic stalled;
    beat = 0; pushed = 0; pend = 0; stalled = 0; acks_b = 0;
    // A competes throughout but last owner was A, so B wins the tie.
    bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_addr = 32'h0000_0AAA;
    bus.i_b_cyc = 1; bus.i_b_stb = 1; bus.i_b_we = 1; bus.i_b_addr = 32'h100; bus.i_b_data = 32'hB000;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL burst_idle got %b want 00", bus.o_grant); end
    nxt();
    for (int c = 0; c < 8; c++) begin
      bus.i_wb_ack  = pend;
      bus.i_wb_data = 32'h1000 + 32'(pushed);
      if (pend) begin
        exp_q.push_back({1'b1, 32'h1000 + 32'(pushed)});
        pushed++;
      end
      bus.i_wb_stall = (beat == 1 && !stalled);
      bus.i_b_stb    = (beat < 4);
      bus.i_b_addr   = 32'h100 + 32'(beat);
      bus.i_b_data   = 32'hB000 + 32'(beat);
      obs();
      n_cmp++; if (bus.o_a_stall !== 1'b1) begin n_bad++; $display("FAIL burst_a_stall c%0d got %b want 1", c, bus.o_a_stall); end
      pend = 0;
      if (bus.o_wb_stb && !bus.i_wb_stall) begin
        n_cmp++; if (bus.o_wb_addr !== 32'h100 + 32'(beat) || bus.o_wb_we !== 1'b1) begin
          n_bad++; $display("FAIL burst_addr beat%0d got %h/%b want %h/1", beat, bus.o_wb_addr, bus.o_wb_we, 32'h100 + 32'(beat));
        end
        beat++;
        pend = 1;
      end
      if (bus.i_wb_stall) stalled = 1;
      nxt();
    end
    bus.i_wb_ack = 0; bus.i_wb_stall = 0; bus.i_b_cyc = 0; bus.i_b_stb = 0; bus.i_b_we = 0;
    n_cmp++; if (beat != 4 || acks_b != 4) begin n_bad++; $display("FAIL burst_count beats/acks got %0d/%0d want 4/4", beat, acks_b); end
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL burst_release got %b want 0", bus.o_wb_cyc); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL burst_then_a got %b want 01", bus.o_grant); end
    nxt();
    bus.i_a_cyc = 0; bus.i_a_stb = 0;
    nxt();
  endtask

  task automatic test_err();
    bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_we = 1; bus.i_a_addr = 32'h20; bus.i_a_data = 32'h1234_5678;
    obs();
    nxt();
    bus.i_b_cyc = 1;
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01 || bus.o_wb_data !== 32'h1234_5678) begin n_bad++; $display("FAIL err_grant got %b/%h want 01/12345678", bus.o_grant, bus.o_wb_data); end
    nxt();
    bus.i_a_stb = 0; bus.i_wb_err = 1;
    obs();
    n_cmp++; if (bus.o_a_err !== 1'b1 || bus.o_b_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse a/b got %b/%b want 1/0", bus.o_a_err, bus.o_b_err); end
    n_cmp++; if (bus.o_b_stall !== 1'b1) begin n_bad++; $display("FAIL err_b_stall got %b want 1", bus.o_b_stall); end
    nxt();
    bus.i_wb_err = 0;
    obs();
    n_cmp++; if (bus.o_a_err !== 1'b0 || bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL err_hold got %b/%b want 0/01", bus.o_a_err, bus.o_grant); end
    nxt();
    bus.i_a_cyc = 0; bus.i_a_we = 0;
    obs();
    n_cmp++; if (bus.o_wb_cyc !== 1'b0) begin n_bad++; $display("FAIL err_release got %b want 0", bus.o_wb_cyc); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b10) begin n_bad++; $display("FAIL err_then_b got %b want 10", bus.o_grant); end
    nxt();
    bus.i_b_cyc = 0;
    nxt();
  endtask

  task automatic test_reset_mid();
    bus.i_a_cyc = 1;
    nxt();
    nxt();
    bus.i_a_cyc = 0; bus.i_b_cyc = 1; bus.i_b_stb = 1; bus.i_b_addr = 32'h300;
    obs();
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b10 || bus.o_wb_stb !== 1'b1) begin n_bad++; $display("FAIL rmid_own_b got %b/%b want 10/1", bus.o_grant, bus.o_wb_stb); end
    nxt();
    bus.i_b_stb = 0; bus.i_wb_ack = 1; bus.i_wb_data = 32'h5555_AAAA;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_wb_cyc !== 1'b0 || bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL rmid_abort got %b/%b want 0/00", bus.o_wb_cyc, bus.o_grant); end
    n_cmp++; if (bus.o_b_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack_lost got %b want 0", bus.o_b_ack); end
    obs();
    nxt();
    i_rst_n = 1'b1; bus.i_wb_ack = 0; bus.i_a_cyc = 1;
    obs();
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b01) begin n_bad++; $display("FAIL rmid_tie got %b want 01", bus.o_grant); end
    nxt();
    bus.i_a_cyc = 0; bus.i_b_cyc = 0;
    nxt();
    nxt();
  endtask

`ifdef WBARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_addr = 32'h40;
    obs();
    nxt();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) bus.i_a_stb = 0;
      if (k == 3) bus.i_b_cyc = 1;
      obs();
      if (k < 8) begin
        n_cmp++; if (bus.o_a_err !== 1'b0 || bus.o_wb_cyc !== 1'b1) begin n_bad++; $display("FAIL to_wait k%0d err/cyc got %b/%b want 0/1", k, bus.o_a_err, bus.o_wb_cyc); end
      end else begin
        n_cmp++; if (bus.o_a_err !== 1'b1 || bus.o_wb_cyc !== 1'b0 || bus.o_b_err !== 1'b0) begin
          n_bad++; $display("FAIL to_fire a_err/cyc/b_err got %b/%b/%b want 1/0/0", bus.o_a_err, bus.o_wb_cyc, bus.o_b_err);
        end
      end
      nxt();
    end
    for (int k = 0; k < 2; k++) begin
      obs();
      n_cmp++; if (bus.o_a_err !== 1'b0 || bus.o_a_stall !== 1'b1 || bus.o_wb_cyc !== 1'b0) begin
        n_bad++; $display("FAIL to_drain k%0d err/stall/cyc got %b/%b/%b want 0/1/0", k, bus.o_a_err, bus.o_a_stall, bus.o_wb_cyc);
      end
      nxt();
    end
    bus.i_a_cyc = 0;
    obs();
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b00) begin n_bad++; $display("FAIL to_idle got %b want 00", bus.o_grant); end
    nxt();
    obs();
    n_cmp++; if (bus.o_grant !== 2'b10 || bus.o_wb_cyc !== 1'b1) begin n_bad++; $display("FAIL to_then_b got %b/%b want 10/1", bus.o_grant, bus.o_wb_cyc); end
    nxt();
    bus.i_b_cyc = 0;
    nxt();
  endtask
`endif

  initial begin
    test_reset();
    test_a_read();
    test_tie();
    test_b_burst();
    test_err();
    test_reset_mid();
`ifdef WBARB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover got %0d pending acks want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
